// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, default
// oversampling ratio and the parity helper used by both TX and RX.
package uart_pkg;

  localparam int DATA_W          = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic parity(input logic mode, input logic [DATA_W-1:0] data);
    return mode ^ (^data);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, data LSB first, optional parity, stop bit(s),
// each bit held for OVERSAMPLE clocks. tx, busy and done are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int   OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int   PARITY_EN   = 1,
  parameter logic PARITY_MODE = 1'b0,
  parameter int   STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              wrsig,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_e       state_r, state_nxt_s;
  logic [TICK_W-1:0] tick_r, tick_nxt_s;
  logic [BIT_W-1:0]  bit_r, bit_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic              parity_r;
  logic              tx_r, busy_r, done_r;
  logic              tx_nxt_s, busy_nxt_s, done_nxt_s;
  logic              tick_end_s;

  assign tick_end_s = (tick_r == TICK_LAST);

  // State, counters, latched byte and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      tick_r   <= '0;
      bit_r    <= '0;
      data_r   <= '0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= tick_nxt_s;
      bit_r   <= bit_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      if (state_r == IDLE && wrsig) begin
        data_r   <= datain;
        parity_r <= parity(PARITY_MODE, datain);
      end
    end
  end

  // Next state, tick counter and bit index (bit index also counts stop bits)
  always_comb begin
    state_nxt_s = state_r;
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    case (state_r)
      IDLE: begin
        tick_nxt_s = '0;
        bit_nxt_s  = '0;
        if (wrsig) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (tick_end_s) begin
          state_nxt_s = DATA;
          tick_nxt_s  = '0;
          bit_nxt_s   = '0;
        end else begin
          tick_nxt_s = tick_r + TICK_W'(1);
        end
      end
      DATA: begin
        if (tick_end_s) begin
          tick_nxt_s = '0;
          if (bit_r == BIT_LAST) begin
            bit_nxt_s = '0;
            if (PARITY_EN != 0) begin
              state_nxt_s = PARITY;
            end else begin
              state_nxt_s = STOP;
            end
          end else begin
            bit_nxt_s = bit_r + BIT_W'(1);
          end
        end else begin
          tick_nxt_s = tick_r + TICK_W'(1);
        end
      end
      PARITY: begin
        if (tick_end_s) begin
          state_nxt_s = STOP;
          tick_nxt_s  = '0;
          bit_nxt_s   = '0;
        end else begin
          tick_nxt_s = tick_r + TICK_W'(1);
        end
      end
      STOP: begin
        if (tick_end_s) begin
          tick_nxt_s = '0;
          if (bit_r == STOP_LAST) begin
            state_nxt_s = IDLE;
            bit_nxt_s   = '0;
          end else begin
            bit_nxt_s = bit_r + BIT_W'(1);
          end
        end else begin
          tick_nxt_s = tick_r + TICK_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tick_nxt_s  = '0;
        bit_nxt_s   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so tx is registered
  always_comb begin
    tx_nxt_s   = 1'b1;
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r == STOP) && (state_nxt_s == IDLE);
    case (state_nxt_s)
      IDLE:    tx_nxt_s = 1'b1;
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = data_r[bit_nxt_s];
      PARITY:  tx_nxt_s = parity_r;
      STOP:    tx_nxt_s = 1'b1;
      default: tx_nxt_s = 1'b1;
    endcase
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-clock line checks against a frame model plus
// an oversampling receiver that pops expected bytes from a scoreboard queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n, wrsig, wrsig_np;
  logic [7:0] datain, datain_np;
  logic       tx, busy, done, tx_np, busy_np, done_np;

  int         vectors     = 0;
  int         miscompares = 0;
  int         rx_count    = 0;
  int         sent_count  = 0;
  logic [7:0] exp_q[$];
  bit         rst_seen    = 1'b0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .wrsig(wrsig),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_tx #(.PARITY_EN(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .datain(datain_np), .wrsig(wrsig_np),
    .tx(tx_np), .busy(busy_np), .done(done_np)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k clocks after the accepting edge (16x, even parity, 1 stop)
  function automatic logic exp_tx(input logic [7:0] b, input int k, input bit pe);
    int slot;
    slot = k / 16;
    if (slot == 0)            return 1'b0;
    else if (slot <= 8)       return b[slot-1];
    else if (pe && slot == 9) return ^b;
    else                      return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] b, input bit push);
    @(negedge clk);
    datain = b;
    wrsig  = 1'b1;
    if (push) begin
      exp_q.push_back(b);
      sent_count++;
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input int inject_at, input bit hold,
                             input bit chain, input logic [7:0] next_b);
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (!hold) wrsig = 1'b0;
      chk("tx_bit", tx, exp_tx(b, k, 1'b1));
      chk("busy_frame", busy, 1);
      chk("done_frame", done, 0);
      if (k == inject_at) begin
        wrsig  = 1'b1;
        datain = 8'hFF;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("tx_stop_gap", tx, 1);
    if (chain) begin
      datain = next_b;
      wrsig  = 1'b1;
      exp_q.push_back(next_b);
      sent_count++;
    end else begin
      wrsig = 1'b0;
      @(negedge clk);
      chk("done_once", done, 0);
      chk("busy_idle", busy, 0);
      chk("tx_idle", tx, 1);
    end
  endtask

  task automatic check_np(input logic [7:0] b);
    @(negedge clk);
    datain_np = b;
    wrsig_np  = 1'b1;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      wrsig_np = 1'b0;
      chk("np_tx_bit", tx_np, exp_tx(b, k, 1'b0));
      chk("np_busy", busy_np, 1);
    end
    @(negedge clk);
    chk("np_done", done_np, 1);
    chk("np_busy_end", busy_np, 0);
    chk("np_tx_idle", tx_np, 1);
  endtask

  always @(posedge clk) if (rst_n === 1'b0) rst_seen = 1'b1;

  // Loopback receiver: samples mid-bit at 16x and checks each frame against the queue
  initial begin : rx_monitor
    logic [7:0] rx_byte, exp_b;
    logic       rx_start, rx_par, rx_stop;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (8) @(negedge clk);
        rx_start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (16) @(negedge clk);
        rx_par = tx;
        repeat (16) @(negedge clk);
        rx_stop = tx;
        if (!rst_seen) begin
          rx_count++;
          chk("rx_start", rx_start, 0);
          chk("rx_stop", rx_stop, 1);
          chk("rx_frame_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("rx_byte", rx_byte, exp_b);
            chk("rx_parity", rx_par, ^exp_b);
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    wrsig     = 1'b0;
    datain    = 8'h00;
    wrsig_np  = 1'b0;
    datain_np = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_np_tx", tx_np, 1);
    chk("reset_np_busy", busy_np, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", tx, 1);

    start_frame(8'h55, 1'b1);
    check_frame(8'h55, -1, 1'b0, 1'b0, 8'h00);
    start_frame(8'h01, 1'b1);
    check_frame(8'h01, -1, 1'b0, 1'b0, 8'h00);

    check_np(8'h01);
    check_np(8'h55);

    // Request while busy must be ignored; datain change must not leak into the frame
    start_frame(8'hA5, 1'b1);
    check_frame(8'hA5, 40, 1'b0, 1'b0, 8'h00);

    // Held request: second frame starts on the done cycle
    start_frame(8'h3C, 1'b1);
    check_frame(8'h3C, -1, 1'b1, 1'b1, 8'hC3);
    check_frame(8'hC3, -1, 1'b1, 1'b0, 8'h00);

    // Reset and request on the same edge: reset wins
    @(negedge clk);
    rst_n  = 1'b0;
    wrsig  = 1'b1;
    datain = 8'h77;
    @(negedge clk);
    chk("rstwin_tx", tx, 1);
    chk("rstwin_busy", busy, 0);
    rst_n = 1'b1;
    wrsig = 1'b0;
    @(negedge clk);
    chk("rstwin_dropped", busy, 0);

    // Reset at clock 70 of a frame aborts it without a done pulse
    start_frame(8'h96, 1'b0);
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk);
      wrsig = 1'b0;
      chk("abort_tx_bit", tx, exp_tx(8'h96, k, 1'b1));
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end

    start_frame(8'h00, 1'b1);
    check_frame(8'h00, -1, 1'b0, 1'b0, 8'h00);
    start_frame(8'hFF, 1'b1);
    check_frame(8'hFF, -1, 1'b0, 1'b0, 8'h00);
    start_frame(8'hA5, 1'b1);
    check_frame(8'hA5, -1, 1'b0, 1'b0, 8'h00);
    start_frame(8'h5A, 1'b1);
    check_frame(8'h5A, -1, 1'b0, 1'b0, 8'h00);

    repeat (20) @(negedge clk);
    chk("rx_strobes", rx_count, sent_count);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
